// File: rtl/boreal_host_loader.sv
// Host frame parser for the Boreal weight/LUT memory write port (Port B).
// Decodes SYNC/ADDR/LEN/DATA/CHK frames from a byte stream into 32-bit word writes.
module boreal_host_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  we_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] din_b,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [2:0]            dbg_state
);

    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_LO, S_ADDR_HI, S_LEN, S_DATA, S_WRITE, S_CHK
    } state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [8:0]            words_left;
    logic [1:0]            byte_cnt;
    logic [DATA_WIDTH-1:0] word_sr;
    logic [7:0]            chk_q;
    logic [TW-1:0]         tcnt;
    logic                  accept;
    logic                  timed;
    logic                  timeout_hit;

    // Handshake: a byte transfers on any posedge where rx_valid && rx_ready; rx_ready
    // is a registered decode of the next state, low only during WRITE and reset.
    assign accept    = rx_valid && rx_ready;
    assign timed     = (state != S_IDLE) && (state != S_WRITE);
    assign dbg_state = state;

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:    if (accept && rx_data == 8'hA5) next_state = S_ADDR_LO;
            S_ADDR_LO: if (accept) next_state = S_ADDR_HI;
            S_ADDR_HI: if (accept) next_state = S_LEN;
            S_LEN:     if (accept) next_state = S_DATA;
            S_DATA:    if (accept && byte_cnt == 2'd3) next_state = S_WRITE;
            S_WRITE:   next_state = (words_left == 9'd1) ? S_CHK : S_DATA;
            S_CHK:     if (accept) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (timed && !accept && tcnt == T_LAST) begin
            timeout_hit = 1'b1;
            next_state  = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rx_ready   <= 1'b0;
            we_b       <= 1'b0;
            addr_b     <= '0;
            din_b      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            addr_q     <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            word_sr    <= '0;
            chk_q      <= '0;
            tcnt       <= '0;
        end else begin
            state    <= next_state;
            rx_ready <= (next_state != S_WRITE);
            busy     <= (next_state != S_IDLE);
            we_b     <= (next_state == S_WRITE);
            done     <= 1'b0;
            err      <= 1'b0;

            if (!timed || accept || timeout_hit) tcnt <= '0;
            else                                 tcnt <= tcnt + 1'b1;

            case (state)
                S_IDLE: if (accept && rx_data == 8'hA5) begin
                    err_code <= 2'd0;
                    chk_q    <= 8'h00;
                end
                S_ADDR_LO: if (accept) begin
                    addr_q[7:0] <= rx_data;
                    chk_q       <= chk_q ^ rx_data;
                end
                S_ADDR_HI: if (accept) begin
                    addr_q <= ADDR_WIDTH'({rx_data, addr_q[7:0]});
                    chk_q  <= chk_q ^ rx_data;
                end
                S_LEN: if (accept) begin
                    words_left <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    byte_cnt   <= 2'd0;
                    chk_q      <= chk_q ^ rx_data;
                end
                S_DATA: if (accept) begin
                    // LSB-first: each new byte enters at the top and shifts down
                    word_sr  <= {rx_data, word_sr[DATA_WIDTH-1:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                    chk_q    <= chk_q ^ rx_data;
                    if (byte_cnt == 2'd3) begin
                        din_b  <= {rx_data, word_sr[DATA_WIDTH-1:8]};
                        addr_b <= addr_q;
                    end
                end
                S_WRITE: begin
                    addr_q     <= addr_q + 1'b1;
                    words_left <= words_left - 9'd1;
                end
                S_CHK: if (accept) begin
                    if (rx_data == chk_q) begin
                        done <= 1'b1;
                    end else begin
                        err      <= 1'b1;
                        err_code <= 2'd1;
                    end
                end
                default: ;
            endcase

            if (timeout_hit) begin
                err      <= 1'b1;
                err_code <= 2'd2;
                byte_cnt <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_boreal_host_loader.sv
// Directed bench for boreal_host_loader: frame table plus hand-written timeout
// and mid-frame reset sequences, with a write scoreboard on Port B.
module tb_boreal_host_loader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int W  = AW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [2:0]    dbg_state;

    boreal_host_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .dbg_state(dbg_state)
    );

    // clock/reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rdy_low = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [7:0]          alo;
        logic [7:0]          ahi;
        logic [7:0]          len;
        logic [3:0][31:0]    words;
        logic                bad_chk;
        int                  gap_max;
        logic [3:0][AW-1:0]  exp_addr;
        logic                exp_done;
        logic [1:0]          exp_code;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // scoreboard: every write must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n) begin
            if (!rx_ready) rdy_low++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (we_b) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none", {addr_b, din_b});
                end else begin
                    check("write", 64'({addr_b, din_b}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // driver: entered and left at posedge+1
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (!rx_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_stall actual=0 required=1");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        logic [7:0] cs;
        int n, s_cyc, c_cyc;
        n = int'(v.len);
        for (int i = 0; i < n; i++) exp_q.push_back({v.exp_addr[i], v.words[i]});
        wr_cnt = 0; rdy_low = 0; done_cnt = 0; err_cnt = 0;
        send_byte(8'hA5, $urandom_range(0, v.gap_max));
        s_cyc = cyc;
        cs = v.alo ^ v.ahi ^ v.len;
        send_byte(v.alo, $urandom_range(0, v.gap_max));
        send_byte(v.ahi, $urandom_range(0, v.gap_max));
        send_byte(v.len, $urandom_range(0, v.gap_max));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ v.words[i][8*k +: 8];
                send_byte(v.words[i][8*k +: 8], $urandom_range(0, v.gap_max));
            end
        end
        if (v.bad_chk) cs = cs ^ 8'h01;
        send_byte(cs, $urandom_range(0, v.gap_max));
        c_cyc = cyc;
        check($sformatf("f%0d_done_now", idx), 64'(done), 64'(v.exp_done));
        check($sformatf("f%0d_err_now", idx), 64'(err), 64'(!v.exp_done));
        check($sformatf("f%0d_busy_now", idx), 64'(busy), 64'd0);
        check($sformatf("f%0d_state_idle", idx), 64'(dbg_state), 64'd0);
        if (v.gap_max == 0)
            check($sformatf("f%0d_frame_cycles", idx), 64'(c_cyc - s_cyc), 64'(4 + 5 * n));
        @(posedge clk);
        #1;
        check($sformatf("f%0d_done_pulses", idx), 64'(done_cnt), 64'(v.exp_done));
        check($sformatf("f%0d_err_pulses", idx), 64'(err_cnt), 64'(!v.exp_done));
        check($sformatf("f%0d_writes", idx), 64'(wr_cnt), 64'(n));
        check($sformatf("f%0d_ready_low", idx), 64'(rdy_low), 64'(n));
        check($sformatf("f%0d_exp_left", idx), 64'(exp_q.size()), 64'd0);
        check($sformatf("f%0d_err_code", idx), 64'(err_code), 64'(v.exp_code));
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_we_b"}, 64'(we_b), 64'd0);
        check({tag, "_addr_b"}, 64'(addr_b), 64'd0);
        check({tag, "_din_b"}, 64'(din_b), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_err_code"}, 64'(err_code), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        tbl[0] = '{alo: 8'h10, ahi: 8'h00, len: 8'd1,
                   words: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, bad_chk: 1'b0, gap_max: 0,
                   exp_addr: {10'h0, 10'h0, 10'h0, 10'h010}, exp_done: 1'b1, exp_code: 2'd0};
        tbl[1] = '{alo: 8'hFE, ahi: 8'h03, len: 8'd3,
                   words: {32'h0, 32'd3, 32'd2, 32'd1}, bad_chk: 1'b0, gap_max: 0,
                   exp_addr: {10'h0, 10'h000, 10'h3FF, 10'h3FE}, exp_done: 1'b1, exp_code: 2'd0};
        tbl[2] = '{alo: 8'h10, ahi: 8'h00, len: 8'd1,
                   words: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, bad_chk: 1'b1, gap_max: 0,
                   exp_addr: {10'h0, 10'h0, 10'h0, 10'h010}, exp_done: 1'b0, exp_code: 2'd1};
        tbl[3] = '{alo: 8'h05, ahi: 8'hFC, len: 8'd2,
                   words: {32'h0, 32'h0, 32'hA5A5A5A5, 32'h12345678}, bad_chk: 1'b0, gap_max: 10,
                   exp_addr: {10'h0, 10'h0, 10'h006, 10'h005}, exp_done: 1'b1, exp_code: 2'd0};
        tbl[4] = tbl[0];
        tbl[4].gap_max = 10;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("por_ready_after", 64'(rx_ready), 64'd1);

        // junk bytes in IDLE are swallowed
        wr_cnt = 0;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 1);
        check("junk_busy", 64'(busy), 64'd0);
        check("junk_state", 64'(dbg_state), 64'd0);
        check("junk_writes", 64'(wr_cnt), 64'd0);

        for (int i = 0; i < 3; i++) run_frame(tbl[i], i);

        // timeout after one data byte
        wr_cnt = 0; done_cnt = 0;
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        k = 0;
        while (!err && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("to_cycles", 64'(k), 64'd16);
        check("to_err_code", 64'(err_code), 64'd2);
        check("to_busy", 64'(busy), 64'd0);
        check("to_done", 64'(done_cnt), 64'd0);
        check("to_writes", 64'(wr_cnt), 64'd0);
        @(posedge clk);
        #1;
        check("to_err_pulse", 64'(err), 64'd0);
        check("to_code_hold", 64'(err_code), 64'd2);

        // reset after the third data byte
        wr_cnt = 0;
        send_byte(8'hA5, 0);
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("mid");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_writes", 64'(wr_cnt), 64'd0);
        check("mid_state", 64'(dbg_state), 64'd0);

        run_frame(tbl[0], 5);
        run_frame(tbl[3], 3);
        run_frame(tbl[4], 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
